// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the quotient reported for a zero divisor.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int WIDTH_DEFAULT = 4;
  localparam int WIDTH_MAX     = 16;

  // All-ones quotient for a zero divisor; the top level keeps the low WIDTH bits.
  localparam logic [WIDTH_MAX-1:0] DBZ_QUOTIENT = '1;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift the partial remainder left by one bit,
// bringing in the next dividend bit, then subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = div_pkg::WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] d,
  input  logic             q_msb,
  output logic [WIDTH:0]   r_out,
  output logic             q_bit
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_d_inv;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH+1:0] w_carry;
  logic             w_unused_msb;

  // The partial remainder is always below the divisor, so its top bit is
  // zero on entry and is shifted out without loss.
  assign w_unused_msb = r_in[WIDTH];
  assign w_shifted    = {r_in[WIDTH-1:0], q_msb};

  // Two's-complement subtract: add the inverted divisor with carry-in 1.
  assign w_d_inv    = ~{1'b0, d};
  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    full_adder u_fa (
      .i_a   (w_shifted[i]),
      .i_b   (w_d_inv[i]),
      .i_cin (w_carry[i]),
      .o_sum (w_diff[i]),
      .o_cout(w_carry[i+1])
    );
  end

  // Carry out set means no borrow: shifted remainder >= divisor, keep the difference.
  assign q_bit = w_carry[WIDTH+1];
  assign r_out = q_bit ? w_diff : w_shifted;

endmodule : div_step

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the divider's ripple subtractor.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule : full_adder

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/done handshake that accepts a new operation in the DONE cycle.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH:0]   w_r_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_q_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in (r_r),
    .d    (r_d),
    .q_msb(r_q[WIDTH-1]),
    .r_out(w_r_next),
    .q_bit(w_q_bit)
  );

  assign w_q_next = {r_q[WIDTH-2:0], w_q_bit};

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the values from before the edge, like real flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (divisor != '0) begin
              r_q     <= dividend;
              r_d     <= divisor;
              r_r     <= '0;
              r_cnt   <= CNT_W'(WIDTH - 1);
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end else begin
              // Zero divisor needs no iterations: report straight away.
              r_quotient  <= DBZ_QUOTIENT[WIDTH-1:0];
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= ST_DONE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next[WIDTH-1:0];
            r_dbz       <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_DONE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus an exhaustive
// sweep with randomly toggled operands, checked against plain / and % arithmetic.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: integer division, with the zero-divisor rule applied separately.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic z, output int lat);
    if (b == 0) begin
      q = {W{1'b1}}; r = a; z = 1'b1; lat = 0;
    end else begin
      q = a / b; r = a % b; z = 1'b0; lat = W;
    end
  endtask

  // Issue one division; lat counts edges after the accepting edge until done is seen.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit toggle,
                         output int lat, output bit timeout);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (toggle) begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    timeout = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (quotient !== '0) begin n_fail++; $display("FAIL reset_quotient: got %0d want 0", quotient); end
    n_checks++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_remainder: got %0d want 0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_latency();
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL busy_window step %0d: busy=%b done=%b want busy=1 done=0", k, busy, done);
      end
      @(posedge clk); #1;
    end
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL done_13_3: done=%b busy=%b want 1/0", done, busy); end
    n_checks++; if (quotient !== 4'd4) begin n_fail++; $display("FAIL quot_13_3: got %0d want 4", quotient); end
    n_checks++; if (remainder !== 4'd1) begin n_fail++; $display("FAIL rem_13_3: got %0d want 1", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_13_3: got %b want 0", div_by_zero); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b want 0", done); end
    n_checks++; if (quotient !== 4'd4 || remainder !== 4'd1) begin n_fail++; $display("FAIL hold_idle: got %0d r%0d want 4 r1", quotient, remainder); end
  endtask

  task automatic test_div_zero();
    int lat; bit to;
    run_div(4'd9, 4'd0, 1'b0, lat, to);
    n_checks++; if (to || lat != 0) begin n_fail++; $display("FAIL dbz_latency: got %0d (timeout %b) want 0", lat, to); end
    n_checks++; if (quotient !== 4'd15 || remainder !== 4'd9 || div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL dbz_9_0: got q=%0d r=%0d z=%b want q=15 r=9 z=1", quotient, remainder, div_by_zero);
    end
    run_div(4'd8, 4'd2, 1'b0, lat, to);
    n_checks++; if (to || lat != W) begin n_fail++; $display("FAIL lat_8_2: got %0d (timeout %b) want %0d", lat, to, W); end
    n_checks++; if (quotient !== 4'd4 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL after_dbz_8_2: got q=%0d r=%0d z=%b want q=4 r=0 z=0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] as [3] = '{4'd7, 4'd15, 4'd0};
    logic [W-1:0] bs [3] = '{4'd9, 4'd1, 4'd5};
    logic [W-1:0] eq, er; logic ez; int el, lat; bit to;
    for (int i = 0; i < 3; i++) begin
      model(as[i], bs[i], eq, er, ez, el);
      run_div(as[i], bs[i], 1'b0, lat, to);
      n_checks++;
      if (to || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
        n_fail++;
        $display("FAIL boundary %0d/%0d: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                 as[i], bs[i], quotient, remainder, div_by_zero, eq, er, ez);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_checks++; if (quotient !== 4'd3 || remainder !== 4'd2 || lat != W) begin
      n_fail++; $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d want q=3 r=2 lat=%0d", quotient, remainder, lat, W);
    end
    // Request the next division while done is still high.
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat != W + 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d edges want %0d", lat, W + 1); end
    n_checks++; if (quotient !== 4'd5 || remainder !== 4'd1) begin
      n_fail++; $display("FAIL b2b_second: got q=%0d r=%0d want q=5 r=1", quotient, remainder);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; bit to; bit saw_done;
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset: busy=%b done=%b q=%0d r=%0d z=%b want all 0",
                         busy, done, quotient, remainder, div_by_zero);
    end
    saw_done = 1'b0;
    repeat (W + 2) begin @(posedge clk); #1; if (done === 1'b1) saw_done = 1'b1; end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL abandoned_done: got done pulse want none"); end
    run_div(4'd12, 4'd5, 1'b0, lat, to);
    n_checks++; if (to || quotient !== 4'd2 || remainder !== 4'd2) begin
      n_fail++; $display("FAIL after_reset_12_5: got q=%0d r=%0d want q=2 r=2", quotient, remainder);
    end
  endtask

  task automatic test_exhaustive();
    logic [W-1:0] eq, er; logic ez; int el, lat; bit to;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        model(W'(a), W'(b), eq, er, ez, el);
        run_div(W'(a), W'(b), 1'b1, lat, to);
        n_checks++;
        if (to || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
          n_fail++;
          $display("FAIL exh %0d/%0d: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                   a, b, quotient, remainder, div_by_zero, eq, er, ez);
        end
        n_checks++;
        if (lat != el) begin n_fail++; $display("FAIL exh_lat %0d/%0d: got %0d want %0d", a, b, lat, el); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_latency();
    test_div_zero();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_divider
